// File: rtl/control_sequencer_pkg.sv
// control_pkg: shared definitions for the control sequencer.
//   - state_e : FSM state encodings (observable on the 'state' port)
//   - cause_e : sticky trap cause codes
//   - CLS_*   : instruction class field values (ir[INSTR_W-1:INSTR_W-2])
//   - clog2   : ceiling log2, used to size the memory-wait counter
package control_pkg;

    typedef enum logic [2:0] {
        ST_HALT    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_EXEC    = 3'd2,
        ST_WAIT_LD = 3'd3,
        ST_WAIT_ST = 3'd4,
        ST_TRAP    = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CAUSE_NONE    = 3'd0,
        CAUSE_FETCH   = 3'd1,
        CAUSE_DATA    = 3'd2,
        CAUSE_ILLEGAL = 3'd3,
        CAUSE_TIMEOUT = 3'd4
    } cause_e;

    localparam logic [1:0] CLS_MEM     = 2'b00;
    localparam logic [1:0] CLS_SPECIAL = 2'b01;
    localparam logic [1:0] CLS_ARITH   = 2'b10;
    localparam logic [1:0] CLS_JUMP    = 2'b11;

    // Smallest r such that 2**r >= value.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/control_sequencer_wait_watchdog.sv
// wait_watchdog: bounded memory-wait counter.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : force the count to zero (held while outside a wait phase)
//   enable     : count one cycle
//   expired    : count has reached LIMIT-1, i.e. this is the LIMIT-th wait cycle
module wait_watchdog
    import control_pkg::*;
#(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // LIMIT+1 keeps the width at least one bit when LIMIT is 1.
    localparam int CW = clog2(LIMIT + 1);

    logic [CW-1:0] count_r;

    // Wait-cycle counter; clear has priority over enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable) begin
            count_r <= count_r + CW'(1);
        end
    end

    assign expired = (count_r == CW'(LIMIT - 1));

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: instruction phase sequencer (FETCH -> EXEC -> [WAIT_LD|WAIT_ST]).
// Holds the instruction register, gates register-write / PC / jump / load / store
// strobes by phase, and records a sticky trap cause that 'go' clears on restart.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   go, halt              start/resume request, stop request at instruction boundary
//   instr, instr_valid    fetched word and its valid qualifier
//   instr_segv, data_segv fetch fault, data access fault
//   data_done             load/store completion
//   dec_invalid/ld/st/write  decoder results for ir
//   ir                    instruction register
//   reg_write, pc_inc, jump, ld, st   phase-gated strobes (combinational from state)
//   state, trap_pending, trap_cause   status
// Build option: CONTROL_SEQUENCER_SINGLE_STEP_EN makes every commit return to HALT,
// so each go pulse executes one instruction.
module control_sequencer
    import control_pkg::*;
#(
    parameter int INSTR_W    = 32,
    parameter int WP         = 2,
    parameter int WAIT_LIMIT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               go,
    input  logic               halt,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    input  logic               instr_segv,
    input  logic               data_segv,
    input  logic               data_done,
    input  logic               dec_invalid,
    input  logic               dec_ld,
    input  logic               dec_st,
    input  logic [WP-1:0]      dec_write,
    output logic [INSTR_W-1:0] ir,
    output logic [WP-1:0]      reg_write,
    output logic               pc_inc,
    output logic               jump,
    output logic               ld,
    output logic               st,
    output logic [2:0]         state,
    output logic               trap_pending,
    output logic [2:0]         trap_cause
);

`ifdef CONTROL_SEQUENCER_SINGLE_STEP_EN
    localparam state_e COMMIT_STATE = ST_HALT;
`else
    localparam state_e COMMIT_STATE = ST_FETCH;
`endif

    state_e             state_r, state_s;
    logic [INSTR_W-1:0] ir_r, ir_s;
    logic [2:0]         cause_r, cause_s;
    logic [1:0]         cls_s;
    logic               in_wait_s;
    logic               wd_clear_s;
    logic               wd_expired_s;

    assign cls_s      = ir_r[INSTR_W-1:INSTR_W-2];
    assign in_wait_s  = (state_r == ST_WAIT_LD) || (state_r == ST_WAIT_ST);
    // Holding the counter clear outside WAIT guarantees a fresh count on each entry.
    assign wd_clear_s = !in_wait_s;

    wait_watchdog #(
        .LIMIT (WAIT_LIMIT)
    ) u_wait_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear_s),
        .enable  (in_wait_s),
        .expired (wd_expired_s)
    );

    // State, instruction and cause registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_HALT;
            ir_r    <= '0;
            cause_r <= CAUSE_NONE;
        end else begin
            state_r <= state_s;
            ir_r    <= ir_s;
            cause_r <= cause_s;
        end
    end

    // Next-state, register updates and phase-gated strobes.
    always_comb begin
        state_s   = state_r;
        ir_s      = ir_r;
        cause_s   = cause_r;
        reg_write = '0;
        pc_inc    = 1'b0;
        jump      = 1'b0;
        ld        = 1'b0;
        st        = 1'b0;
        case (state_r)
            ST_HALT: begin
                if (go && !halt) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_HALT;
                end
            end
            ST_FETCH: begin
                if (instr_segv) begin
                    state_s = ST_TRAP;
                    cause_s = CAUSE_FETCH;
                end else if (halt) begin
                    state_s = ST_HALT;
                end else if (instr_valid) begin
                    ir_s    = instr;
                    state_s = ST_EXEC;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_EXEC: begin
                if (dec_invalid) begin
                    state_s = ST_TRAP;
                    cause_s = CAUSE_ILLEGAL;
                end else if ((cls_s == CLS_MEM) && dec_ld) begin
                    ld      = 1'b1;
                    state_s = ST_WAIT_LD;
                end else if ((cls_s == CLS_MEM) && dec_st) begin
                    st      = 1'b1;
                    state_s = ST_WAIT_ST;
                end else begin
                    // Jump-class leaves the PC to the jump path; special-class holds it.
                    reg_write = dec_write;
                    pc_inc    = !cls_s[0];
                    jump      = (cls_s == CLS_JUMP);
                    state_s   = COMMIT_STATE;
                end
            end
            ST_WAIT_LD, ST_WAIT_ST: begin
                ld = (state_r == ST_WAIT_LD);
                st = (state_r == ST_WAIT_ST);
                if (data_segv) begin
                    state_s = ST_TRAP;
                    cause_s = CAUSE_DATA;
                end else if (data_done) begin
                    if (state_r == ST_WAIT_LD) begin
                        reg_write = dec_write;
                    end else begin
                        reg_write = '0;
                    end
                    pc_inc  = 1'b1;
                    state_s = COMMIT_STATE;
                end else if (wd_expired_s) begin
                    state_s = ST_TRAP;
                    cause_s = CAUSE_TIMEOUT;
                end else begin
                    state_s = state_r;
                end
            end
            ST_TRAP: begin
                if (go && !halt) begin
                    cause_s = CAUSE_NONE;
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_TRAP;
                end
            end
            default: begin
                state_s = ST_HALT;
            end
        endcase
    end

    assign ir           = ir_r;
    assign state        = state_r;
    assign trap_pending = (state_r == ST_TRAP);
    assign trap_cause   = cause_r;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

    localparam int IW  = 32;
    localparam int WPW = 2;
    localparam int LIM = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           go = 1'b0, halt = 1'b0, instr_valid = 1'b0, instr_segv = 1'b0;
    logic           data_segv = 1'b0, data_done = 1'b0;
    logic           dec_invalid = 1'b0, dec_ld = 1'b0, dec_st = 1'b0;
    logic [IW-1:0]  instr = '0;
    logic [WPW-1:0] dec_write = '0;
    logic [IW-1:0]  ir;
    logic [WPW-1:0] reg_write;
    logic           pc_inc, jump, ld, st, trap_pending;
    logic [2:0]     state, trap_cause;

    int tests = 0;
    int fails = 0;

    control_sequencer #(
        .INSTR_W    (IW),
        .WP         (WPW),
        .WAIT_LIMIT (LIM)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .go           (go),
        .halt         (halt),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_segv   (instr_segv),
        .data_segv    (data_segv),
        .data_done    (data_done),
        .dec_invalid  (dec_invalid),
        .dec_ld       (dec_ld),
        .dec_st       (dec_st),
        .dec_write    (dec_write),
        .ir           (ir),
        .reg_write    (reg_write),
        .pc_inc       (pc_inc),
        .jump         (jump),
        .ld           (ld),
        .st           (st),
        .state        (state),
        .trap_pending (trap_pending),
        .trap_cause   (trap_cause)
    );

    always #5 clk = ~clk;

    // ctl = {go, halt, instr_valid, instr_segv, data_segv, data_done, dec_invalid, dec_ld, dec_st}
    // estb = {pc_inc, jump, ld, st}; expectations are the outputs during the cycle.
    typedef struct {
        logic [8:0]     ctl;
        logic [IW-1:0]  ins;
        logic [WPW-1:0] dw;
        logic [2:0]     e_state;
        logic [WPW-1:0] e_rw;
        logic [3:0]     e_stb;
        logic [2:0]     e_cause;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [8:0] ctl, logic [IW-1:0] ins, logic [WPW-1:0] dw,
                                logic [2:0] es, logic [WPW-1:0] erw, logic [3:0] estb,
                                logic [2:0] ec);
        vec_t v;
        v.ctl = ctl; v.ins = ins; v.dw = dw;
        v.e_state = es; v.e_rw = erw; v.e_stb = estb; v.e_cause = ec;
        return v;
    endfunction

    task automatic drive(input logic [8:0] ctl, input logic [IW-1:0] ins, input logic [WPW-1:0] dw);
        {go, halt, instr_valid, instr_segv, data_segv, data_done, dec_invalid, dec_ld, dec_st} = ctl;
        instr     = ins;
        dec_write = dw;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: phase, held instruction, sticky cause, cycles spent waiting.
    int          m_phase;   // 0 halt,1 fetch,2 exec,3 wait-ld,4 wait-st,5 trap
    logic [31:0] m_ir;
    int          m_cause;
    int          m_waited;

`ifdef CONTROL_SEQUENCER_SINGLE_STEP_EN
    localparam int AFTER_COMMIT = 0;
`else
    localparam int AFTER_COMMIT = 1;
`endif

    task automatic model_cycle();
        int          np, nc, nw;
        logic [31:0] nir;
        logic [1:0]  e_rw;
        logic [3:0]  e_stb;
        int          cls;
        np = m_phase; nc = m_cause; nw = m_waited; nir = m_ir;
        e_rw = 2'b00; e_stb = 4'b0000;
        cls = int'(m_ir[31:30]);
        if (m_phase == 0) begin
            if (go && !halt) np = 1;
        end else if (m_phase == 1) begin
            if (instr_segv) begin np = 5; nc = 1; end
            else if (halt) np = 0;
            else if (instr_valid) begin nir = instr; np = 2; end
        end else if (m_phase == 2) begin
            if (dec_invalid) begin np = 5; nc = 3; end
            else if (cls == 0 && dec_ld) begin e_stb = 4'b0010; np = 3; nw = 0; end
            else if (cls == 0 && dec_st) begin e_stb = 4'b0001; np = 4; nw = 0; end
            else begin
                e_rw  = dec_write;
                e_stb = {(cls == 0 || cls == 2) ? 1'b1 : 1'b0, (cls == 3) ? 1'b1 : 1'b0, 2'b00};
                np    = AFTER_COMMIT;
            end
        end else if (m_phase == 3 || m_phase == 4) begin
            e_stb = (m_phase == 3) ? 4'b0010 : 4'b0001;
            if (data_segv) begin np = 5; nc = 2; end
            else if (data_done) begin
                e_rw  = (m_phase == 3) ? dec_write : 2'b00;
                e_stb = e_stb | 4'b1000;
                np    = AFTER_COMMIT;
            end else if (m_waited + 1 >= LIM) begin np = 5; nc = 4; end
            else nw = m_waited + 1;
        end else begin
            if (go && !halt) begin np = 1; nc = 0; end
        end
        check("rand_outputs",
              {32'(state), 32'(trap_cause), 26'(reg_write), pc_inc, jump, ld, st, trap_pending, 1'b0},
              {32'(m_phase), 32'(m_cause), 26'(e_rw), e_stb, (m_phase == 5) ? 1'b1 : 1'b0, 1'b0});
        check("rand_ir", 64'(ir), 64'(m_ir));
        m_phase = np; m_cause = nc; m_waited = nw; m_ir = nir;
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        #1;
        check("reset_state", {ir, 8'(state), 8'(trap_cause), 2'(reg_write), pc_inc, jump, ld, st, trap_pending, 3'b000},
              64'h0);
        @(negedge clk);
        reset = 1'b0;

`ifdef CONTROL_SEQUENCER_SINGLE_STEP_EN
        vecs.push_back(mk(9'b100000000, 32'h0,         2'b00, 3'd0, 2'b00, 4'b0000, 3'd0));
        vecs.push_back(mk(9'b001000000, 32'h8000_0001, 2'b00, 3'd1, 2'b00, 4'b0000, 3'd0));
        vecs.push_back(mk(9'b000000000, 32'h0,         2'b11, 3'd2, 2'b11, 4'b1000, 3'd0));
        vecs.push_back(mk(9'b000000000, 32'h0,         2'b00, 3'd0, 2'b00, 4'b0000, 3'd0));
        vecs.push_back(mk(9'b000000000, 32'h0,         2'b00, 3'd0, 2'b00, 4'b0000, 3'd0));
        vecs.push_back(mk(9'b100000000, 32'h0,         2'b00, 3'd0, 2'b00, 4'b0000, 3'd0));
        vecs.push_back(mk(9'b001000000, 32'h8000_0002, 2'b00, 3'd1, 2'b00, 4'b0000, 3'd0));
        vecs.push_back(mk(9'b000000000, 32'h0,         2'b01, 3'd2, 2'b01, 4'b1000, 3'd0));
        vecs.push_back(mk(9'b000000000, 32'h0,         2'b00, 3'd0, 2'b00, 4'b0000, 3'd0));
`else
        // arith run
        vecs.push_back(mk(9'b100000000, 32'h0,         2'b00, 3'd0, 2'b00, 4'b0000, 3'd0));
        vecs.push_back(mk(9'b001000000, 32'h8000_0001, 2'b00, 3'd1, 2'b00, 4'b0000, 3'd0));
        vecs.push_back(mk(9'b000000000, 32'h0,         2'b11, 3'd2, 2'b11, 4'b1000, 3'd0));
        // jump
        vecs.push_back(mk(9'b001000000, 32'hC000_0000, 2'b00, 3'd1, 2'b00, 4'b0000, 3'd0));
        vecs.push_back(mk(9'b000000000, 32'h0,         2'b01, 3'd2, 2'b01, 4'b0100, 3'd0));
        // load, done in 3rd wait cycle
        vecs.push_back(mk(9'b001000000, 32'h0000_0000, 2'b00, 3'd1, 2'b00, 4'b0000, 3'd0));
        vecs.push_back(mk(9'b000000010, 32'h0,         2'b10, 3'd2, 2'b00, 4'b0010, 3'd0));
        vecs.push_back(mk(9'b000000010, 32'h0,         2'b10, 3'd3, 2'b00, 4'b0010, 3'd0));
        vecs.push_back(mk(9'b000000010, 32'h0,         2'b10, 3'd3, 2'b00, 4'b0010, 3'd0));
        vecs.push_back(mk(9'b000001010, 32'h0,         2'b10, 3'd3, 2'b10, 4'b1010, 3'd0));
        // store timeout after LIM wait cycles, then restart
        vecs.push_back(mk(9'b001000000, 32'h0000_0000, 2'b00, 3'd1, 2'b00, 4'b0000, 3'd0));
        vecs.push_back(mk(9'b000000001, 32'h0,         2'b11, 3'd2, 2'b00, 4'b0001, 3'd0));
        vecs.push_back(mk(9'b000000001, 32'h0,         2'b11, 3'd4, 2'b00, 4'b0001, 3'd0));
        vecs.push_back(mk(9'b000000001, 32'h0,         2'b11, 3'd4, 2'b00, 4'b0001, 3'd0));
        vecs.push_back(mk(9'b000000001, 32'h0,         2'b11, 3'd4, 2'b00, 4'b0001, 3'd0));
        vecs.push_back(mk(9'b000000001, 32'h0,         2'b11, 3'd4, 2'b00, 4'b0001, 3'd0));
        vecs.push_back(mk(9'b000000000, 32'h0,         2'b00, 3'd5, 2'b00, 4'b0000, 3'd4));
        vecs.push_back(mk(9'b100000000, 32'h0,         2'b00, 3'd5, 2'b00, 4'b0000, 3'd4));
        // data_done together with data_segv
        vecs.push_back(mk(9'b001000000, 32'h0000_0000, 2'b00, 3'd1, 2'b00, 4'b0000, 3'd0));
        vecs.push_back(mk(9'b000000010, 32'h0,         2'b11, 3'd2, 2'b00, 4'b0010, 3'd0));
        vecs.push_back(mk(9'b000011010, 32'h0,         2'b11, 3'd3, 2'b00, 4'b0010, 3'd0));
        vecs.push_back(mk(9'b000000000, 32'h0,         2'b00, 3'd5, 2'b00, 4'b0000, 3'd2));
        // illegal, halt blocks restart, halt in fetch
        vecs.push_back(mk(9'b100000000, 32'h0,         2'b00, 3'd5, 2'b00, 4'b0000, 3'd2));
        vecs.push_back(mk(9'b001000000, 32'h8000_0000, 2'b00, 3'd1, 2'b00, 4'b0000, 3'd0));
        vecs.push_back(mk(9'b000000100, 32'h0,         2'b11, 3'd2, 2'b00, 4'b0000, 3'd0));
        vecs.push_back(mk(9'b110000000, 32'h0,         2'b00, 3'd5, 2'b00, 4'b0000, 3'd3));
        vecs.push_back(mk(9'b100000000, 32'h0,         2'b00, 3'd5, 2'b00, 4'b0000, 3'd3));
        vecs.push_back(mk(9'b010000000, 32'h0,         2'b00, 3'd1, 2'b00, 4'b0000, 3'd0));
        // fetch fault beats a valid fetch
        vecs.push_back(mk(9'b100000000, 32'h0,         2'b00, 3'd0, 2'b00, 4'b0000, 3'd0));
        vecs.push_back(mk(9'b001100000, 32'h8000_0000, 2'b00, 3'd1, 2'b00, 4'b0000, 3'd0));
        vecs.push_back(mk(9'b000000000, 32'h0,         2'b00, 3'd5, 2'b00, 4'b0000, 3'd1));
        vecs.push_back(mk(9'b100000000, 32'h0,         2'b00, 3'd5, 2'b00, 4'b0000, 3'd1));
        vecs.push_back(mk(9'b010000000, 32'h0,         2'b00, 3'd1, 2'b00, 4'b0000, 3'd0));
`endif
        foreach (vecs[i]) begin
            drive(vecs[i].ctl, vecs[i].ins, vecs[i].dw);
            #1;
            check($sformatf("vec%0d", i),
                  {40'h0, 8'(state), 2'(reg_write), pc_inc, jump, ld, st, 5'(trap_cause), 1'b0},
                  {40'h0, 8'(vecs[i].e_state), vecs[i].e_rw, vecs[i].e_stb, 5'(vecs[i].e_cause), 1'b0});
            @(negedge clk);
        end

        // Return to HALT before the reset-in-wait sequence.
        drive(9'b000000000, 32'h0, 2'b00);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        drive(9'b100000000, 32'h0, 2'b00);
        @(negedge clk);
        drive(9'b001000000, 32'h0000_1234, 2'b00);
        @(negedge clk);
        drive(9'b000000010, 32'h0, 2'b11);
        @(negedge clk);
        #1;
        check("wait_ld_before_reset", {40'h0, 8'(state), ld, ir[15:0], 7'h0}, {40'h0, 8'd3, 1'b1, 16'h1234, 7'h0});
        reset = 1'b1;
        #1;
        check("reset_mid_wait", {8'(state), 2'(reg_write), ld, st, pc_inc, ir, 19'h0, trap_pending, trap_cause},
              64'h0);
        @(negedge clk);
        drive(9'b000000000, 32'h0, 2'b00);
        reset = 1'b0;

        // Randomized run against the reference model, starting from HALT.
        m_phase = 0; m_ir = 32'h0; m_cause = 0; m_waited = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            go          = ($urandom_range(0, 1) == 0);
            halt        = ($urandom_range(0, 7) == 0);
            instr       = $urandom;
            instr_valid = ($urandom_range(0, 1) == 0);
            instr_segv  = ($urandom_range(0, 19) == 0);
            data_segv   = ($urandom_range(0, 19) == 0);
            data_done   = ($urandom_range(0, 3) == 0);
            dec_invalid = ($urandom_range(0, 9) == 0);
            dec_ld      = ($urandom_range(0, 2) == 0);
            dec_st      = ($urandom_range(0, 2) == 0);
            dec_write   = 2'($urandom_range(0, 3));
            #1;
            model_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Parametrised successor to the processor control FSM. It sequences each instruction through fetch, execute and memory-wait phases, and holds the instruction register. It gates register-write, PC and load/store strobes by phase, and records trap causes in a sticky register. New relative to the previous generation: configurable instruction and write-port widths, a bounded memory-wait watchdog, trap cause reporting with go-based restart, and optional single-step.

Parameters:
INSTR_W, 32, instruction word width; the class field is instr[INSTR_W-1:INSTR_W-2].
WP, 2, width of the register-write enable vector.
WAIT_LIMIT, 255, maximum cycles spent in WAIT_LD/WAIT_ST before a timeout trap; must be ≥1.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
go  in  1  start/resume request
halt  in  1  stop request, honoured at instruction boundary
instr  in  INSTR_W  fetched instruction word
instr_valid  in  1  instr is valid this cycle
instr_segv  in  1  fetch fault
data_segv  in  1  data access fault
data_done  in  1  load/store completed this cycle
dec_invalid  in  1  decoder flags ir as illegal (combinational from ir)
dec_ld  in  1  decoded instruction is a load
dec_st  in  1  decoded instruction is a store
dec_write  in  WP  decoded register-write enables
ir  out  INSTR_W  instruction register
reg_write  out  WP  gated register-write enables
pc_inc  out  1  advance PC this cycle
jump  out  1  jump-class commit strobe
ld  out  1  load request
st  out  1  store request
state  out  3  current state encoding
trap_pending  out  1  high while in TRAP
trap_cause  out  3  sticky cause code

Behaviour:
- Reset (async, any state): state=HALT; ir, trap_cause and the wait counter = 0; all strobes 0.
- Class field: c[1]=ir[INSTR_W-1] (alu), c[0]=ir[INSTR_W-2] (pc). 00 mem, 01 special, 10 arith, 11 jump.
- HALT: go&~halt -> FETCH; otherwise remain.
- FETCH transitions, in priority order:
  - instr_segv -> TRAP, cause=1.
  - halt -> HALT.
  - instr_valid -> ir<=instr, -> EXEC.
  - otherwise remain.
- EXEC (decoder inputs refer to ir), in priority order:
  - dec_invalid -> TRAP, cause=3; no strobes.
  - c==00 & dec_ld -> ld=1, -> WAIT_LD.
  - c==00 & dec_st -> st=1, -> WAIT_ST. If dec_ld and dec_st are both set, load wins.
  - Else commit this cycle: reg_write=dec_write, pc_inc=~c[0], jump=c[1]&c[0]; -> FETCH.
- WAIT_LD/WAIT_ST: ld (or st) held at 1; the counter increments each cycle. Priority order:
  - data_segv -> TRAP, cause=2.
  - data_done -> commit (WAIT_LD: reg_write=dec_write; WAIT_ST: reg_write=0); pc_inc=1; -> FETCH.
  - counter==WAIT_LIMIT-1 -> TRAP, cause=4.
  - The counter clears on every WAIT entry. If data_segv and data_done assert together, segv wins.
- TRAP: trap_pending=1, all strobes 0, cause held. go&~halt clears the cause and goes -> FETCH. No PC increment occurs for the faulting instruction.
- All strobes are combinational from state plus registered ir/decoder inputs, with 0-cycle latency within a state. Exactly one commit occurs per instruction.
- State encodings: HALT=0, FETCH=1, EXEC=2, WAIT_LD=3, WAIT_ST=4, TRAP=5. Codes 6–7 are unreachable and recover to HALT.
- Cause codes: 0 none, 1 fetch fault, 2 data fault, 3 illegal, 4 timeout.

Optional Feature:
CONTROL_SEQUENCER_SINGLE_STEP_EN
- Defined: a commit returns to HALT instead of FETCH, so each go pulse executes exactly one instruction. Traps are unaffected.
- Undefined: continuous execution as specified above.

Decomposition:
- Package control_pkg: state encodings, trap cause codes, class codes, and function clog2 for the counter width.
- Natural sub-module: wait_watchdog, a parametrised counter with clear, enable and expired outputs.

Test Plan:
- Arith run: reset, go=1; instr=0x8000_0001 valid. Expect EXEC with reg_write=dec_write, pc_inc=1, jump=0, then FETCH.
- Jump: instr=0xC000_0000. Expect EXEC with jump=1, pc_inc=0.
- Load with 3-cycle wait: class 00, dec_ld=1, data_done in the 3rd WAIT cycle. Expect ld high 4 cycles, then reg_write=dec_write and pc_inc=1 once.
- Store timeout with WAIT_LIMIT=4 and no data_done: expect TRAP after 4 WAIT cycles, cause=4, st drops. Then go -> FETCH with cause=0.
- Simultaneous data_done and data_segv in WAIT_LD: expect TRAP, cause=2, no reg_write.
- Reset asserted mid-WAIT_LD: expect immediate HALT, ld=0, ir=0. With SINGLE_STEP_EN, two arith instructions need two go pulses.
